// File: rtl/mem_ctrl_if.sv
// Core request/response and byte-wide RAM signals for mem_ctrl.
// MEM_CTRL_SEXT_EN adds req_signed for sign-extended byte/half loads.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 17
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [31:0]           req_addr;
  logic [1:0]            req_size;
  logic [31:0]           req_wdata;
`ifdef MEM_CTRL_SEXT_EN
  logic                  req_signed;
`endif
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  mem_en;
  logic                  mem_r_nw;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic [7:0]            mem_d_out;
  logic [7:0]            mem_d_in;

  // Environment side: core issuing requests plus the RAM returning read bytes.
  modport master (
    output req_valid, req_we, req_addr, req_size, req_wdata,
`ifdef MEM_CTRL_SEXT_EN
    output req_signed,
`endif
    output mem_d_in,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_en, mem_r_nw, mem_a, mem_d_out
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_wdata,
`ifdef MEM_CTRL_SEXT_EN
    input  req_signed,
`endif
    input  mem_d_in,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_en, mem_r_nw, mem_a, mem_d_out
  );
endinterface

// File: rtl/mem_ctrl.sv
// Splits byte/half/word loads and stores into 1/2/4 byte accesses on a byte-wide RAM.
// Optional MEM_CTRL_SEXT_EN: sign-extends byte/half loads when req_signed is set.
//
// state | meaning
// IDLE  | ready for a request; response pulse cycle
// LOAD  | issuing read addresses, capturing bytes one cycle behind
// STORE | issuing write addresses with data
// LTAIL | capturing the final load byte, producing the response
module mem_ctrl #(
  parameter int ADDR_WIDTH = 17
) (
  input logic     clk_in,
  input logic     rst_in,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, LTAIL} state_t;

  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [1:0]            last_q, last_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           data_q, data_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_r_nw_q, mem_r_nw_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            mem_d_out_q, mem_d_out_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  ld_signed;
  logic [1:0]            lane;
  logic [1:0]            nxt_idx;
  logic [31:0]           ld_word;
  logic                  addr_hi_unused;

`ifdef MEM_CTRL_SEXT_EN
  logic sext_q, sext_d;
  assign ld_signed = sext_q;
`else
  assign ld_signed = 1'b0;
`endif

  assign addr_hi_unused = ^bus.req_addr[31:ADDR_WIDTH];

  assign bus.req_ready = (state_q == IDLE) && !rst_in;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_r_nw  = mem_r_nw_q;
  assign bus.mem_a     = mem_a_q;
  assign bus.mem_d_out = mem_d_out_q;

  // Read data lags its address by one cycle, so the byte arriving now belongs to idx_q-1.
  assign lane    = idx_q - 2'd1;
  assign nxt_idx = idx_q + 2'd1;

  always_comb begin
    ld_word = data_q;
    ld_word[{lane, 3'b000} +: 8] = bus.mem_d_in;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    mem_en_d    = 1'b0;
    mem_r_nw_d  = 1'b1;
    mem_a_d     = mem_a_q;
    mem_d_out_d = mem_d_out_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef MEM_CTRL_SEXT_EN
    sext_d      = sext_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          unique case (bus.req_size)
            2'd0:    last_d = 2'd0;
            2'd1:    last_d = 2'd1;
            default: last_d = 2'd3;
          endcase
          state_d    = bus.req_we ? STORE : LOAD;
          idx_d      = 2'd0;
          wdata_d    = bus.req_wdata;
          mem_en_d   = 1'b1;
          mem_r_nw_d = !bus.req_we;
          mem_a_d    = bus.req_addr[ADDR_WIDTH-1:0];
          if (bus.req_we) mem_d_out_d = bus.req_wdata[7:0];
`ifdef MEM_CTRL_SEXT_EN
          sext_d     = bus.req_signed;
`endif
        end
      end
      STORE: begin
        if (idx_q == last_q) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
        end else begin
          idx_d       = nxt_idx;
          mem_en_d    = 1'b1;
          mem_r_nw_d  = 1'b0;
          mem_a_d     = mem_a_q + A_ONE;
          mem_d_out_d = wdata_q[{nxt_idx, 3'b000} +: 8];
        end
      end
      LOAD: begin
        if (idx_q != 2'd0) data_d = ld_word;
        idx_d = nxt_idx;
        if (idx_q == last_q) begin
          state_d = LTAIL;
        end else begin
          mem_en_d = 1'b1;
          mem_a_d  = mem_a_q + A_ONE;
        end
      end
      LTAIL: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        unique case (last_q)
          2'd0:    rsp_rdata_d = {{24{ld_signed & ld_word[7]}}, ld_word[7:0]};
          2'd1:    rsp_rdata_d = {{16{ld_signed & ld_word[15]}}, ld_word[15:0]};
          default: rsp_rdata_d = ld_word;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      last_q      <= 2'd0;
      wdata_q     <= '0;
      data_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_r_nw_q  <= 1'b1;
      mem_a_q     <= '0;
      mem_d_out_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef MEM_CTRL_SEXT_EN
      sext_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      mem_en_q    <= mem_en_d;
      mem_r_nw_q  <= mem_r_nw_d;
      mem_a_q     <= mem_a_d;
      mem_d_out_q <= mem_d_out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef MEM_CTRL_SEXT_EN
      sext_q      <= sext_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-array RAM device, reference memory model,
// directed corner cases and randomized traffic.
module tb_mem_ctrl;
  localparam int AW    = 17;
  localparam int RSIZE = 1 << AW;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  mem_ctrl_if #(.ADDR_WIDTH(AW)) bus();
  mem_ctrl #(.ADDR_WIDTH(AW)) dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));

  // RAM device: synchronous write, registered read (data valid the cycle after the address).
  logic [7:0] ram [0:RSIZE-1];
  logic [7:0] ram_rd;
  always @(posedge clk_in) begin
    if (bus.mem_en) begin
      if (bus.mem_r_nw) ram_rd <= ram[bus.mem_a];
      else              ram[bus.mem_a] <= bus.mem_d_out;
    end
  end
  assign bus.mem_d_in = ram_rd;

  logic [7:0]  ref_mem [0:RSIZE-1];
  logic [31:0] last_rdata;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [AW-1:0] base, input logic [1:0] size,
                                             input logic sgn);
    logic [31:0] v;
    int n;
    n = nbytes(size);
    v = 32'd0;
    for (int k = 0; k < n; k++)
      v = v | (32'(ref_mem[(int'(base) + k) % RSIZE]) << (8 * k));
`ifdef MEM_CTRL_SEXT_EN
    if (sgn && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (sgn && n == 2 && v[15]) v = v | 32'hFFFF_0000;
`else
    if (sgn && n == 4) v = v;
`endif
    return v;
  endfunction

  task automatic set_req(input logic vld, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] wdata, input logic sgn);
    bus.req_valid  = vld;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_size   = size;
    bus.req_wdata  = wdata;
`ifdef MEM_CTRL_SEXT_EN
    bus.req_signed = sgn;
`else
    if (sgn) bus.req_wdata = wdata;
`endif
  endtask

  // Called at a negedge; returns at the negedge of the response cycle (an idle cycle).
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, input logic sgn);
    int n, wt, rsp_at;
    logic [AW-1:0] base, a;
    logic [31:0] exp;
    logic exp_en, exp_rsp;
    n    = nbytes(size);
    base = addr[AW-1:0];
    set_req(1'b1, we, addr, size, wdata, sgn);
    wt = 0;
    while (!bus.req_ready && wt < 20) begin
      @(negedge clk_in);
      wt++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    exp = 32'd0;
    if (we) begin
      for (int k = 0; k < n; k++) ref_mem[(int'(base) + k) % RSIZE] = wdata[8*k +: 8];
    end else begin
      exp = model_load(base, size, sgn);
    end
    rsp_at = we ? n + 1 : n + 2;
    for (int cyc = 1; cyc <= rsp_at; cyc++) begin
      @(negedge clk_in);
      exp_en  = (cyc <= n);
      exp_rsp = (cyc == rsp_at);
      a       = base + AW'(cyc - 1);
      chk("mem_en", 32'(bus.mem_en), 32'(exp_en));
      chk("mem_r_nw", 32'(bus.mem_r_nw), exp_en ? 32'(!we) : 32'd1);
      if (exp_en) chk("mem_a", 32'(bus.mem_a), 32'(a));
      if (exp_en && we) chk("mem_d_out", 32'(bus.mem_d_out), 32'(wdata[8*(cyc-1) +: 8]));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rsp));
      if (exp_rsp) begin
        if (!we) last_rdata = exp;
        chk(we ? "rdata_store_hold" : "rdata_load", bus.rsp_rdata, last_rdata);
      end else begin
        // garbage on the request lines while busy must be ignored
        set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
                2'($urandom_range(0, 3)), $urandom(), 1'($urandom_range(0, 1)));
      end
    end
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr, wd, exp;
    logic [1:0]  size;
    logic        sgn, we;
    int acc, rsp_cnt, en_cnt, last_rsp;
    logic [31:0] expq[$];

    last_rdata = 32'd0;
    rst_in = 1'b1;
    set_req(1'b1, 1'b0, 32'd0, 2'd0, 32'd0, 1'b0);
    repeat (3) @(negedge clk_in);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_r_nw", 32'(bus.mem_r_nw), 32'd1);
    chk("rst_mem_a", 32'(bus.mem_a), 32'd0);
    chk("rst_mem_d_out", 32'(bus.mem_d_out), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst_in = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk_in);

    // Preload the contiguous (wrapping) window 0x1FFC0..0x0007F with known data.
    for (int j = 0; j < 48; j++)
      do_req(1'b1, 32'((32'h1FFC0 + 4 * j) % RSIZE), 2'd2, $urandom(), 1'b0);

    // Word load little-endian assembly
    do_req(1'b1, 32'h100, 2'd0, 32'h11, 1'b0);
    do_req(1'b1, 32'h101, 2'd0, 32'h22, 1'b0);
    do_req(1'b1, 32'h102, 2'd0, 32'h33, 1'b0);
    do_req(1'b1, 32'h103, 2'd0, 32'h44, 1'b0);
    do_req(1'b0, 32'h100, 2'd2, 32'd0, 1'b0);
    chk("t1_word", last_rdata, 32'h4433_2211);

    // Half store, byte load of its upper byte
    do_req(1'b1, 32'h2, 2'd1, 32'h1234_BEEF, 1'b0);
    do_req(1'b0, 32'h3, 2'd0, 32'd0, 1'b0);
    chk("t2_byte", last_rdata, 32'h0000_00BE);

    // Half load extension
    do_req(1'b1, 32'h10, 2'd1, 32'h0000_80FF, 1'b0);
    do_req(1'b0, 32'h10, 2'd1, 32'd0, 1'b1);
`ifdef MEM_CTRL_SEXT_EN
    chk("t3_half_signed", last_rdata, 32'hFFFF_80FF);
`else
    chk("t3_half_zext", last_rdata, 32'h0000_80FF);
`endif
    do_req(1'b0, 32'h10, 2'd1, 32'd0, 1'b0);
    chk("t3_half_unsigned", last_rdata, 32'h0000_80FF);

    // Address wrap and truncation
    do_req(1'b0, 32'h0001_FFFF, 2'd2, 32'd0, 1'b0);
    do_req(1'b0, 32'hFFFE_0000, 2'd2, 32'd0, 1'b0);

    // Reset during a word store: only byte 0 lands, no response
    set_req(1'b1, 1'b1, 32'h40, 2'd2, 32'hA1B2_C3D4, 1'b0);
    chk("t5_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk_in);
    bus.req_valid = 1'b0;
    chk("t5_en_c1", 32'(bus.mem_en), 32'd1);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("t5_en_after_rst", 32'(bus.mem_en), 32'd0);
    chk("t5_ready_in_rst", 32'(bus.req_ready), 32'd0);
    rst_in = 1'b0;
    ref_mem[32'h40] = 8'hD4;
    last_rdata = 32'd0;
    rsp_cnt = 0;
    en_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_in);
      if (bus.rsp_valid) rsp_cnt++;
      if (bus.mem_en) en_cnt++;
    end
    chk("t5_no_rsp", 32'(rsp_cnt), 32'd0);
    chk("t5_no_en", 32'(en_cnt), 32'd0);
    chk("t5_rdata_reset", bus.rsp_rdata, 32'd0);
    do_req(1'b0, 32'h40, 2'd2, 32'd0, 1'b0);

    // Queued word loads with valid held high (toggled while busy)
    acc = 0;
    rsp_cnt = 0;
    en_cnt = 0;
    last_rsp = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_in);
      if (bus.mem_en) en_cnt++;
      if (bus.rsp_valid) begin
        exp = (expq.size() > 0) ? expq.pop_front() : 32'hDEAD_DEAD;
        chk("t6_rdata", bus.rsp_rdata, exp);
        if (rsp_cnt > 0) chk("t6_spacing", 32'(c - last_rsp), 32'd6);
        last_rsp = c;
        rsp_cnt++;
      end
      if (acc < 3) begin
        addr = 32'h1FFF0 + 32'(8 * acc);
        set_req(bus.req_ready ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, addr, 2'd2, 32'd0, 1'b0);
        if (bus.req_ready && bus.req_valid) begin
          expq.push_back(model_load(addr[AW-1:0], 2'd2, 1'b0));
          acc++;
        end
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    chk("t6_accepts", 32'(acc), 32'd3);
    chk("t6_rsps", 32'(rsp_cnt), 32'd3);
    chk("t6_en_cycles", 32'(en_cnt), 32'd12);
    bus.req_valid = 1'b0;
    last_rdata = bus.rsp_rdata;

    // Randomized traffic inside the preloaded wrapping window
    for (int i = 0; i < 250; i++) begin
      size = 2'($urandom_range(0, 3));
      we   = 1'($urandom_range(0, 1));
      sgn  = 1'($urandom_range(0, 1));
      wd   = $urandom();
      addr = 32'((32'h1FFC0 + $urandom_range(0, 188)) % RSIZE);
      addr[31:AW] = 15'($urandom());
      do_req(we, addr, size, wd, sgn);
      if ($urandom_range(0, 3) == 0) @(negedge clk_in);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
